// File: rtl/pkg_ram.sv
// Shared RAM-side definitions for dev_ram and the clients arbitrated in front of it.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package pkg_ram;

  localparam int ADDR_W_DEFAULT    = 16;
  localparam int DATA_W_DEFAULT    = 64;
  localparam int N_CLIENTS_DEFAULT = 4;
  localparam int CLIENT_ID_W       = $clog2(N_CLIENTS_DEFAULT);

  typedef logic [CLIENT_ID_W-1:0] client_id_t;

  // Port assignment of the default four-client system
  localparam client_id_t CLIENT_LOADER    = client_id_t'(0);
  localparam client_id_t CLIENT_DEBUGGER  = client_id_t'(1);
  localparam client_id_t CLIENT_CPU_FETCH = client_id_t'(2);
  localparam client_id_t CLIENT_CPU_DATA  = client_id_t'(3);

  // Slot following idx in an n-entry ring; wrap is explicit so n need not be a power of two
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dev_ram_rd_tag_pipe.sv
// Carries {valid, client id} of each read alongside the RAM read pipeline.
// Latency: DEPTH cycles from in_vld to out_vld.
// Backpressure: none; one tag accepted every cycle, reset drops every tag in flight.
module dev_ram_rd_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  input  logic [ID_W-1:0] in_id,
  output logic            out_vld,
  output logic [ID_W-1:0] out_id
);

  logic [DEPTH-1:0]           vld_q;
  logic [DEPTH-1:0][ID_W-1:0] id_q;

  // Shift tags one stage per cycle; reset clears all stages so no stale rvalid appears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= in_vld;
      id_q[0]  <= in_id;
      for (int s = 1; s < DEPTH; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_id  = id_q[DEPTH-1];

endmodule

// File: rtl/dev_ram_arbiter.sv
// N-client single-quad access arbiter with optional bus lock in front of dev_ram.
// Latency: grant and RAM strobe combinational with req; read data READ_LATENCY cycles after grant.
// Backpressure: losing clients hold req until gnt; a lock stalls every client but the holder.
module dev_ram_arbiter
  import pkg_ram::*;
#(
  parameter int N_CLIENTS    = N_CLIENTS_DEFAULT,
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int READ_LATENCY = 1,
  parameter int FIXED_PRIO   = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CLIENTS-1:0]           req,
  input  logic [N_CLIENTS-1:0]           we,
  input  logic [N_CLIENTS-1:0]           lock,
  input  logic [N_CLIENTS*ADDR_W-1:0]    addr,
  input  logic [N_CLIENTS*DATA_W-1:0]    wdata,
  input  logic [N_CLIENTS*DATA_W/8-1:0]  be,
  output logic [N_CLIENTS-1:0]           gnt,
  output logic [N_CLIENTS-1:0]           rvalid,
  output logic [DATA_W-1:0]              rdata,
  output logic [$clog2(N_CLIENTS):0]     owner,
  output logic                           ram_en,
  output logic                           ram_we,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [DATA_W-1:0]              ram_wdata,
  output logic [DATA_W/8-1:0]            ram_be,
  input  logic [DATA_W-1:0]              ram_rdata
);

  localparam int ID_W = $clog2(N_CLIENTS);
  localparam int BE_W = DATA_W / 8;
  localparam logic [ID_W:0] N_EXT = (ID_W + 1)'(N_CLIENTS);

  typedef logic [ID_W-1:0] id_t;

  id_t                  rr_q;
  logic                 locked_q;
  id_t                  owner_q;
  logic [N_CLIENTS-1:0] req_rot;
  logic                 fix_hit, rot_hit;
  id_t                  fix_idx, rot_idx;
  logic [ID_W:0]        rr_sum;
  id_t                  rr_win;
  logic                 gnt_vld;
  id_t                  gnt_id;
  logic                 rd_push;
  logic                 tag_vld;
  id_t                  tag_id;

  // req_rot[j] is the request of client (rr_q + j) mod N
  assign req_rot = N_CLIENTS'({req, req} >> rr_q);

  // Lowest-index hit in both the plain and the rotated request vectors
  always_comb begin
    fix_hit = 1'b0;
    fix_idx = '0;
    rot_hit = 1'b0;
    rot_idx = '0;
    for (int j = N_CLIENTS - 1; j >= 0; j--) begin
      if (req[j]) begin
        fix_hit = 1'b1;
        fix_idx = id_t'(j);
      end
      if (req_rot[j]) begin
        rot_hit = 1'b1;
        rot_idx = id_t'(j);
      end
    end
  end

  assign rr_sum = {1'b0, rr_q} + {1'b0, rot_idx};
  assign rr_win = (rr_sum >= N_EXT) ? id_t'(rr_sum - N_EXT) : rr_sum[ID_W-1:0];

  // Winner selection: the lock holder only while locked, otherwise the chosen policy; nothing in reset
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (rst_n) begin
      if (locked_q) begin
        gnt_vld = req[owner_q];
        gnt_id  = owner_q;
      end else if (FIXED_PRIO != 0) begin
        gnt_vld = fix_hit;
        gnt_id  = fix_idx;
      end else begin
        gnt_vld = rot_hit;
        gnt_id  = rr_win;
      end
    end
  end

  // One-hot grant and RAM port steered from the winning client's fields
  always_comb begin
    gnt       = '0;
    ram_en    = gnt_vld;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_be    = '0;
    if (gnt_vld) begin
      gnt[gnt_id] = 1'b1;
    end
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (gnt_vld && gnt_id == id_t'(i)) begin
        ram_we    = we[i];
        ram_addr  = addr[i*ADDR_W +: ADDR_W];
        ram_wdata = wdata[i*DATA_W +: DATA_W];
        ram_be    = be[i*BE_W +: BE_W];
      end
    end
  end

  // Pointer advances past every winner; lock is taken on a locked grant and released once lock drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else begin
      if (gnt_vld) begin
        rr_q <= id_t'(rr_next(int'(gnt_id), N_CLIENTS));
      end
      if (!locked_q) begin
        if (gnt_vld && lock[gnt_id]) begin
          locked_q <= 1'b1;
          owner_q  <= gnt_id;
        end
      end else if (!lock[owner_q]) begin
        locked_q <= 1'b0;
        owner_q  <= '0;
      end
    end
  end

  assign owner   = {locked_q, owner_q};
  assign rd_push = ram_en & ~ram_we;

  dev_ram_rd_tag_pipe #(
    .DEPTH (READ_LATENCY),
    .ID_W  (ID_W)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rd_push),
    .in_id   (gnt_id),
    .out_vld (tag_vld),
    .out_id  (tag_id)
  );

  // Route returning read data to the client that issued the read
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (tag_vld) begin
      rvalid[tag_id] = 1'b1;
      rdata          = ram_rdata;
    end
  end

endmodule

// File: tb/tb_dev_ram_arbiter.sv
// Directed bench for dev_ram_arbiter: round-robin, fixed-priority and two-cycle-latency variants.
// Latency: each variant has its own RAM model matching its READ_LATENCY.
// Backpressure: all variants share one set of client inputs.
module tb_dev_ram_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int BW = 8;

  logic            clk;
  logic            rst_n;
  logic            mem_clr;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*BW-1:0] be;

  logic [N-1:0]  a_gnt, a_rvalid, b_gnt, b_rvalid, c_gnt, c_rvalid;
  logic [DW-1:0] a_rdata, b_rdata, c_rdata;
  logic [2:0]    a_owner, b_owner, c_owner;
  logic          a_ram_en, a_ram_we, b_ram_en, b_ram_we, c_ram_en, c_ram_we;
  logic [AW-1:0] a_ram_addr, b_ram_addr, c_ram_addr;
  logic [DW-1:0] a_ram_wdata, b_ram_wdata, c_ram_wdata;
  logic [BW-1:0] a_ram_be, b_ram_be, c_ram_be;
  logic [DW-1:0] a_ram_rdata, b_ram_rdata, c_ram_rdata, c_rd1;

  logic [DW-1:0] mem_a [0:63];
  logic [DW-1:0] mem_b [0:63];
  logic [DW-1:0] mem_c [0:63];

  int n_checks;
  int n_fail;

  dev_ram_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata), .be(be),
    .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .owner(a_owner),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
    .ram_be(a_ram_be), .ram_rdata(a_ram_rdata));

  dev_ram_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata), .be(be),
    .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .owner(b_owner),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_be(b_ram_be), .ram_rdata(b_ram_rdata));

  dev_ram_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .FIXED_PRIO(0)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata), .be(be),
    .gnt(c_gnt), .rvalid(c_rvalid), .rdata(c_rdata), .owner(c_owner),
    .ram_en(c_ram_en), .ram_we(c_ram_we), .ram_addr(c_ram_addr), .ram_wdata(c_ram_wdata),
    .ram_be(c_ram_be), .ram_rdata(c_ram_rdata));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] merge_be(input logic [63:0] old, input logic [63:0] nw,
                                           input logic [7:0] bmask);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{bmask[i]}};
    return (old & ~m) | (nw & m);
  endfunction

  // RAM model behind the round-robin instance, one-cycle read latency
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= '0;
      mem_a[16] <= 64'h1111_2222_3333_4444;
      mem_a[32] <= 64'hAAAA_BBBB_CCCC_DDDD;
    end else if (a_ram_en) begin
      if (a_ram_we) mem_a[a_ram_addr[5:0]] <= merge_be(mem_a[a_ram_addr[5:0]], a_ram_wdata, a_ram_be);
      else          a_ram_rdata <= mem_a[a_ram_addr[5:0]];
    end
  end

  // RAM model behind the fixed-priority instance, one-cycle read latency
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= '0;
    end else if (b_ram_en) begin
      if (b_ram_we) mem_b[b_ram_addr[5:0]] <= merge_be(mem_b[b_ram_addr[5:0]], b_ram_wdata, b_ram_be);
      else          b_ram_rdata <= mem_b[b_ram_addr[5:0]];
    end
  end

  // RAM model behind the two-cycle-latency instance
  always @(posedge clk) begin
    c_ram_rdata <= c_rd1;
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_c[i] <= '0;
      mem_c[16] <= 64'h5555_6666_7777_8888;
    end else if (c_ram_en) begin
      if (c_ram_we) mem_c[c_ram_addr[5:0]] <= merge_be(mem_c[c_ram_addr[5:0]], c_ram_wdata, c_ram_be);
      else          c_rd1 <= mem_c[c_ram_addr[5:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    lock  = '0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_exp [0:7];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset state, with every client requesting so the grant gating is exercised
    rst_n = 1'b0; mem_clr = 1'b1;
    req = '1; we = '0; lock = '0; addr = '0; wdata = '0; be = '0;
    next_cycle();
    mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_a_gnt",    a_gnt,    0);
    chk("rst_a_ram_en", a_ram_en, 0);
    chk("rst_a_ram_we", a_ram_we, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_owner",  a_owner,  0);
    chk("rst_b_gnt",    b_gnt,    0);
    chk("rst_c_ram_en", c_ram_en, 0);
    do_reset();

    // Round-robin with all four requesting; fixed priority keeps picking client 0
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr_gnt",    a_gnt,    rr_exp[c]);
      chk("rr_ram_en", a_ram_en, 1);
      chk("fp_all_gnt", b_gnt,   4'b0001);
      next_cycle();
    end
    req = '0;

    // Fixed priority: client 1 beats client 2 until it drops its request
    do_reset();
    req = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("fp_gnt", b_gnt, 4'b0010);
      next_cycle();
    end
    req = 4'b0100;
    @(negedge clk);
    chk("fp_gnt_after_drop", b_gnt, 4'b0100);
    next_cycle();
    req = '0;

    // Back-to-back reads from clients 2 and 0, one-cycle latency
    do_reset();
    req = 4'b0100; addr = 64'h0000_0010_0000_0000;
    @(negedge clk);
    chk("pipe_gnt0",  a_gnt,      4'b0100);
    chk("pipe_addr0", a_ram_addr, 16'h0010);
    next_cycle();
    req = 4'b0001; addr = 64'h0000_0000_0000_0020;
    @(negedge clk);
    chk("pipe_gnt1",    a_gnt,      4'b0001);
    chk("pipe_addr1",   a_ram_addr, 16'h0020);
    chk("pipe_rvalid0", a_rvalid,   4'b0100);
    chk("pipe_rdata0",  a_rdata,    64'h1111_2222_3333_4444);
    next_cycle();
    req = '0;
    @(negedge clk);
    chk("pipe_rvalid1", a_rvalid, 4'b0001);
    chk("pipe_rdata1",  a_rdata,  64'hAAAA_BBBB_CCCC_DDDD);
    next_cycle();
    @(negedge clk);
    chk("pipe_rvalid_idle", a_rvalid, 0);
    next_cycle();

    // Two-cycle latency: normal read returns on the second cycle after grant
    do_reset();
    req = 4'b0010; addr = 64'h0000_0000_0010_0000;
    @(negedge clk);
    chk("l2_gnt", c_gnt, 4'b0010);
    next_cycle();
    req = '0;
    @(negedge clk);
    chk("l2_rvalid_t1", c_rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("l2_rvalid_t2", c_rvalid, 4'b0010);
    chk("l2_rdata_t2",  c_rdata,  64'h5555_6666_7777_8888);
    next_cycle();

    // Two-cycle latency: reset asserted while a read is in flight drops it
    req = 4'b0001; addr = 64'h0000_0000_0000_0010;
    @(negedge clk);
    chk("rstrd_gnt", c_gnt, 4'b0001);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstrd_gnt_in_rst",    c_gnt,    0);
    chk("rstrd_ram_en_in_rst", c_ram_en, 0);
    chk("rstrd_rvalid_in_rst", c_rvalid, 0);
    next_cycle();
    rst_n = 1'b1; req = '0;
    @(negedge clk);
    chk("rstrd_rvalid_t2", c_rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("rstrd_rvalid_t3", c_rvalid, 0);
    next_cycle();

    // Partial write then read-back through client 3
    do_reset();
    req = 4'b1000; we = 4'b1000; addr = 64'h0005_0000_0000_0000;
    wdata = {64'hDEAD_BEEF_0123_4567, 192'h0}; be = {8'h0F, 24'h0};
    @(negedge clk);
    chk("wr_gnt",   a_gnt,       4'b1000);
    chk("wr_we",    a_ram_we,    1);
    chk("wr_addr",  a_ram_addr,  16'h0005);
    chk("wr_be",    a_ram_be,    8'h0F);
    chk("wr_wdata", a_ram_wdata, 64'hDEAD_BEEF_0123_4567);
    next_cycle();
    we = '0;
    @(negedge clk);
    chk("rd_gnt", a_gnt,    4'b1000);
    chk("rd_we",  a_ram_we, 0);
    next_cycle();
    req = '0;
    @(negedge clk);
    chk("rd_rvalid", a_rvalid, 4'b1000);
    chk("rd_rdata",  a_rdata,  64'h0000_0000_0123_4567);
    next_cycle();

    // Lock: client 0 writes 0..7 under lock, client 1 waits until after lock drops
    do_reset();
    be = 32'h0000_00FF;
    for (int k = 0; k < 8; k++) begin
      req   = 4'b0011;
      we    = 4'b0001;
      lock  = (k < 7) ? 4'b0001 : 4'b0000;
      addr  = 64'(k);
      wdata = 256'(k + 100);
      @(negedge clk);
      chk("lock_gnt",   a_gnt,   4'b0001);
      chk("lock_owner", a_owner, (k == 0) ? 3'b000 : 3'b100);
      next_cycle();
    end
    req = 4'b0010; we = '0; lock = '0; addr = '0;
    @(negedge clk);
    chk("unlock_gnt",   a_gnt,   4'b0010);
    chk("unlock_owner", a_owner, 3'b000);
    next_cycle();
    req = '0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
